fetch_unit_ras: RTL and testbench

FETCH_UNIT_RAS -- requirements
Module: fetch_unit_ras

---
 rtl/fetch_pkg.sv | 14 +
 rtl/return_addr_stack.sv | 73 +++++++
 rtl/fetch_unit_ras.sv | 107 ++++++++++
 tb/tb_fetch_unit_ras.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: PC source select and the bubble instruction.
package fetch_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_BRANCH,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack with saturating occupancy count and sticky
// overflow/underflow flags. Pop wins when push and pop coincide.
module return_addr_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o,
    output logic            full_o,
    output logic            overflow_o,
    output logic            underflow_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic            push_en;

    assign push_en     = push_i & ~pop_i;
    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == CW'(RAS_DEPTH));
    assign top_o       = mem_q[ptr_q - PW'(1)];
    assign overflow_o  = ovf_q;
    assign underflow_o = udf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (pop_i) begin
            if (empty_o) begin
                udf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end else if (push_i) begin
            // Pointer always advances; when full this overwrites the oldest entry.
            ptr_d = ptr_q + PW'(1);
            if (full_o) ovf_d = 1'b1;
            else        cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Entry storage needs no reset; only the count defines validity.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit_ras.sv
// Fetch stage: PC register, redirect selection (ret > call > jump > branch)
// and the fetch-to-decode register, with a return-address stack for calls.
module fetch_unit_ras
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              RAS_DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            jump_en,
    input  logic            branch_en,
    input  logic            call_en,
    input  logic            ret_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic [XLEN-1:0] branch_addr,
    input  logic [XLEN-1:0] call_addr,
    output logic            out_valid,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,
    input  logic            out_ready,
    output logic            ras_overflow,
    output logic            ras_underflow
);
    pc_src_e         pc_src;
    logic            advance;
    logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, opc_q, opc_d, opc4_q, opc4_d;
    logic            vld_q, vld_d;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    return_addr_stack #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (call_en & ~ret_en),
        .pop_i       (ret_en),
        .push_data_i (opc4_q),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (),
        .overflow_o  (ras_overflow),
        .underflow_o (ras_underflow)
    );

    assign advance = ~vld_q | out_ready;

    always_comb begin
        pc_src = PC_SEQ;
        if      (ret_en)    pc_src = PC_RET;
        else if (call_en)   pc_src = PC_CALL;
        else if (jump_en)   pc_src = PC_JUMP;
        else if (branch_en) pc_src = PC_BRANCH;
    end

    always_comb begin
        pc_d    = pc_q;
        vld_d   = vld_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        opc4_d  = opc4_q;
        case (pc_src)
            PC_RET:    pc_d = ras_empty ? RESET_PC : ras_top;
            PC_CALL:   pc_d = call_addr;
            PC_JUMP:   pc_d = jump_addr;
            PC_BRANCH: pc_d = branch_addr;
            default:   ;
        endcase
        // A redirect kills the in-flight slot regardless of decode backpressure.
        if (pc_src != PC_SEQ) begin
            vld_d   = 1'b0;
            instr_d = XLEN'(NOP_INSTR);
        end else if (advance) begin
            vld_d   = 1'b1;
            instr_d = imem_rdata;
            opc_d   = pc_q;
            opc4_d  = pc_q + XLEN'(4);
            pc_d    = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            vld_q   <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            opc4_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            opc4_q  <= opc4_d;
        end
    end

    assign imem_addr = pc_q;
    assign out_valid = vld_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;
    assign out_pc4   = opc4_q;

endmodule

// File: tb/tb_fetch_unit_ras.sv
// Randomised and directed checks of fetch_unit_ras against a queue-based model.
module tb_fetch_unit_ras;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          DEPTH  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_rdata;
    logic        jump_en, branch_en, call_en, ret_en, out_ready;
    logic [31:0] jump_addr, branch_addr, call_addr;
    logic        out_valid, ras_overflow, ras_underflow;
    logic [31:0] out_instr, out_pc, out_pc4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc, m_oi, m_op, m_op4;
    logic        m_ov, m_ovf, m_udf;
    logic [31:0] m_ras[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    assign imem_rdata = memf(imem_addr);
    always #5 clk = ~clk;

    fetch_unit_ras #(.XLEN(32), .RAS_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .jump_en(jump_en), .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en),
        .jump_addr(jump_addr), .branch_addr(branch_addr), .call_addr(call_addr),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4),
        .out_ready(out_ready), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    task automatic model_reset();
        m_pc = RST_PC; m_oi = '0; m_op = '0; m_op4 = '0;
        m_ov = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        m_ras.delete();
    endtask

    task automatic drive(input logic j, input logic b, input logic c, input logic r,
                         input logic rdy, input logic [31:0] ja, input logic [31:0] ba,
                         input logic [31:0] ca);
        jump_en = j; branch_en = b; call_en = c; ret_en = r; out_ready = rdy;
        jump_addr = ja; branch_addr = ba; call_addr = ca;
    endtask

    task automatic idle(input logic rdy);
        drive(0, 0, 0, 0, rdy, '0, '0, '0);
    endtask

    // Advance one clock and update the model from the spec's rules.
    task automatic step();
        @(posedge clk);
        if (ret_en) begin
            if (m_ras.size() == 0) begin m_pc = RST_PC; m_udf = 1'b1; end
            else m_pc = m_ras.pop_back();
            m_ov = 1'b0; m_oi = '0;
        end else if (call_en) begin
            if (m_ras.size() == DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1'b1; end
            m_ras.push_back(m_op4);
            m_pc = call_addr; m_ov = 1'b0; m_oi = '0;
        end else if (jump_en) begin
            m_pc = jump_addr; m_ov = 1'b0; m_oi = '0;
        end else if (branch_en) begin
            m_pc = branch_addr; m_ov = 1'b0; m_oi = '0;
        end else if (!m_ov || out_ready) begin
            m_oi = memf(m_pc); m_op = m_pc; m_op4 = m_pc + 32'd4;
            m_ov = 1'b1; m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        #2 model_reset();
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        idle(1'b1);
        reset = 1'b0;
        #12;
        model_reset();
        n_tests++;
        if ({out_valid, out_instr, out_pc, out_pc4, imem_addr, ras_overflow, ras_underflow} !==
            {1'b0, 32'h0, 32'h0, 32'h0, RST_PC, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: got v=%0b i=%h pc=%h pc4=%h a=%h of=%0b uf=%0b, want all zero",
                     out_valid, out_instr, out_pc, out_pc4, imem_addr, ras_overflow, ras_underflow);
        end
        n_tests++;
        if (dut.u_ras.cnt_q !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", dut.u_ras.cnt_q);
        end
        reset = 1'b1;
    endtask

    task automatic test_seq();
        idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({out_valid, out_pc, out_pc4, out_instr} !==
                {1'b1, 32'(4*i), 32'(4*i+4), memf(32'(4*i))}) begin
                n_fail++;
                $display("FAIL seq_%0d: got v=%0b pc=%h pc4=%h i=%h want pc=%h", i,
                         out_valid, out_pc, out_pc4, out_instr, 32'(4*i));
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, a0;
        pc0 = out_pc; a0 = imem_addr;
        idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if ({out_valid, out_pc, out_pc4, out_instr, imem_addr} !==
                {1'b1, pc0, pc0 + 32'd4, memf(pc0), a0}) begin
                n_fail++;
                $display("FAIL stall_%0d: got pc=%h a=%h v=%0b want pc=%h a=%h", i,
                         out_pc, imem_addr, out_valid, pc0, a0);
            end
        end
        idle(1'b1);
        step();
        n_tests++;
        if ({out_valid, out_pc, imem_addr} !== {1'b1, pc0 + 32'd4, a0 + 32'd4}) begin
            n_fail++;
            $display("FAIL stall_resume: got pc=%h a=%h want pc=%h a=%h",
                     out_pc, imem_addr, pc0 + 32'd4, a0 + 32'd4);
        end
    endtask

    task automatic test_jump_branch();
        rst_pulse();
        idle(1'b1); step(); step();
        drive(1, 1, 0, 0, 1'b0, 32'h100, 32'h200, '0);
        step();
        n_tests++;
        if ({imem_addr, out_valid, out_instr, out_pc} !== {32'h100, 1'b0, 32'h0, 32'h4}) begin
            n_fail++;
            $display("FAIL jump_over_branch: got a=%h v=%0b i=%h pc=%h want a=100 v=0 i=0 pc=4",
                     imem_addr, out_valid, out_instr, out_pc);
        end
        idle(1'b0); step();
        n_tests++;
        if ({out_valid, out_pc} !== {1'b1, 32'h100}) begin
            n_fail++; $display("FAIL jump_fetch: got v=%0b pc=%h want 1/100", out_valid, out_pc);
        end
        drive(0, 1, 0, 0, 1'b1, '0, 32'hFFFF_FFFC, '0); step();
        idle(1'b1); step();
        n_tests++;
        if ({out_pc, out_pc4, imem_addr} !== {32'hFFFF_FFFC, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL pc_wrap: got pc=%h pc4=%h a=%h want fffffffc/0/0", out_pc, out_pc4, imem_addr);
        end
    endtask

    task automatic test_call_ret();
        rst_pulse();
        idle(1'b1);
        for (int i = 0; i < 17; i++) step();
        drive(0, 0, 1, 0, 1'b1, '0, '0, 32'h300); step();
        n_tests++;
        if ({out_pc, imem_addr, out_valid, dut.u_ras.cnt_q} !== {32'h40, 32'h300, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL call: got opc=%h a=%h v=%0b cnt=%0d want 40/300/0/1",
                     out_pc, imem_addr, out_valid, dut.u_ras.cnt_q);
        end
        drive(0, 0, 0, 1, 1'b1, '0, '0, '0); step();
        n_tests++;
        if ({imem_addr, dut.u_ras.cnt_q, ras_underflow} !== {32'h44, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ret: got a=%h cnt=%0d uf=%0b want 44/0/0", imem_addr, dut.u_ras.cnt_q, ras_underflow);
        end
    endtask

    task automatic test_overflow();
        rst_pulse();
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0, 1'b1, '0, '0, 32'h1000 + 32'(i) * 32'h100); step();
            idle(1'b1); step();
        end
        n_tests++;
        if ({ras_overflow, ras_underflow, dut.u_ras.cnt_q} !== {1'b1, 1'b0, 4'd8}) begin
            n_fail++;
            $display("FAIL overflow: got of=%0b uf=%0b cnt=%0d want 1/0/8",
                     ras_overflow, ras_underflow, dut.u_ras.cnt_q);
        end
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1, 1'b1, '0, '0, '0); step();
            n_tests++;
            if (imem_addr !== 32'h1004 + 32'(7 - k) * 32'h100) begin
                n_fail++;
                $display("FAIL ovf_ret_%0d: got %h want %h", k, imem_addr, 32'h1004 + 32'(7 - k) * 32'h100);
            end
        end
        step();
        n_tests++;
        if ({imem_addr, ras_underflow, ras_overflow} !== {RST_PC, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL underflow: got a=%h uf=%0b of=%0b want 0/1/1", imem_addr, ras_underflow, ras_overflow);
        end
    endtask

    task automatic test_reset_mid_stall();
        rst_pulse();
        drive(0, 0, 0, 1, 1'b1, '0, '0, '0); step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 1'b1, '0, '0, 32'h500 + 32'(i) * 32'h10); step();
            idle(1'b1); step();
        end
        idle(1'b0); step();
        n_tests++;
        if ({dut.u_ras.cnt_q, out_valid, ras_underflow} !== {4'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset: got cnt=%0d v=%0b uf=%0b want 3/1/1", dut.u_ras.cnt_q, out_valid, ras_underflow);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, out_instr, out_pc, out_pc4, imem_addr, ras_overflow, ras_underflow, dut.u_ras.cnt_q} !==
            {1'b0, 32'h0, 32'h0, 32'h0, RST_PC, 1'b0, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got v=%0b pc=%h a=%h uf=%0b cnt=%0d want zeros",
                     out_valid, out_pc, imem_addr, ras_underflow, dut.u_ras.cnt_q);
        end
        model_reset();
        #2 reset = 1'b1;
        idle(1'b1); step();
        n_tests++;
        if ({out_valid, out_pc, imem_addr} !== {1'b1, RST_PC, RST_PC + 32'd4}) begin
            n_fail++;
            $display("FAIL first_fetch: got v=%0b pc=%h a=%h want 1/0/4", out_valid, out_pc, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt [4];
        tgt[0] = 32'h0000_0080; tgt[1] = 32'h0000_2000; tgt[2] = 32'hFFFF_FFF0; tgt[3] = 32'h0001_0040;
        rst_pulse();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 3) != 0,
                  tgt[$urandom_range(0, 3)], tgt[$urandom_range(0, 3)],
                  {$urandom_range(0, 255), 2'b00} + 32'h4000);
            step();
            n_tests++;
            if ({out_valid, out_instr, out_pc, out_pc4, imem_addr, ras_overflow, ras_underflow, dut.u_ras.cnt_q} !==
                {m_ov, m_oi, m_op, m_op4, m_pc, m_ovf, m_udf, 4'(m_ras.size())}) begin
                n_fail++;
                $display("FAIL random_%0d: got v=%0b pc=%h pc4=%h a=%h of=%0b uf=%0b cnt=%0d want v=%0b pc=%h pc4=%h a=%h of=%0b uf=%0b cnt=%0d",
                         i, out_valid, out_pc, out_pc4, imem_addr, ras_overflow, ras_underflow, dut.u_ras.cnt_q,
                         m_ov, m_op, m_op4, m_pc, m_ovf, m_udf, m_ras.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_jump_branch();
        test_call_ret();
        test_overflow();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
